// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared Y86-64 constants, state type and decode helpers for the memory stage
package mem_stage_pkg;

    localparam int NIBBLE = 4;
    localparam int D_WORD = 64;

    localparam logic [NIBBLE-1:0] IHALT   = 4'h0;
    localparam logic [NIBBLE-1:0] INOP    = 4'h1;
    localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
    localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
    localparam logic [NIBBLE-1:0] IRET    = 4'h9;
    localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
    localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

    localparam logic [NIBBLE-1:0] SBUB = 4'h0;
    localparam logic [NIBBLE-1:0] SAOK = 4'h1;
    localparam logic [NIBBLE-1:0] SHLT = 4'h2;
    localparam logic [NIBBLE-1:0] SADR = 4'h3;
    localparam logic [NIBBLE-1:0] SINS = 4'h4;

    localparam logic [NIBBLE-1:0] RNONE = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    function automatic logic icode_reads(input logic [NIBBLE-1:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
    endfunction

    function automatic logic icode_writes(input logic [NIBBLE-1:0] icode);
        return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
    endfunction

    // Stack pops read at the old stack pointer (valA); everything else uses the ALU result.
    function automatic logic icode_addr_from_vala(input logic [NIBBLE-1:0] icode);
        return (icode == IPOPQ) || (icode == IRET);
    endfunction

    function automatic logic stat_halts(input logic [NIBBLE-1:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus between the memory stage and data memory
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              req;
    logic              we;
    logic [D_WORD-1:0] addr;
    logic [D_WORD-1:0] wdata;
    logic              ack;
    logic              err;
    logic [D_WORD-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );

endinterface

// File: rtl/mem_stage_wb_reg.sv
// rtl/mem_stage_wb_reg.sv - W pipeline register with bubble insertion, resets to a bubble
module mem_stage_wb_reg
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic [NIBBLE-1:0] next_stat,
    input  logic [NIBBLE-1:0] next_icode,
    input  logic [D_WORD-1:0] next_vale,
    input  logic [D_WORD-1:0] next_valm,
    input  logic [NIBBLE-1:0] next_dste,
    input  logic [NIBBLE-1:0] next_dstm,
    output logic [NIBBLE-1:0] stat,
    output logic [NIBBLE-1:0] icode,
    output logic [D_WORD-1:0] vale,
    output logic [D_WORD-1:0] valm,
    output logic [NIBBLE-1:0] dste,
    output logic [NIBBLE-1:0] dstm
);

    // Capture every cycle: either the instruction leaving M or a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            stat  <= SBUB;
            icode <= INOP;
            vale  <= '0;
            valm  <= '0;
            dste  <= RNONE;
            dstm  <= RNONE;
        end else begin
            stat  <= next_stat;
            icode <= next_icode;
            vale  <= next_vale;
            valm  <= next_valm;
            dste  <= next_dste;
            dstm  <= next_dstm;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Y86-64 memory stage: multi-cycle data access, stall, address check, W register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NIBBLE-1:0] M_stat_i,
    input  logic [NIBBLE-1:0] M_icode_i,
    input  logic [D_WORD-1:0] M_valE_i,
    input  logic [D_WORD-1:0] M_valA_i,
    input  logic [NIBBLE-1:0] M_dstE_i,
    input  logic [NIBBLE-1:0] M_dstM_i,
    output logic              m_stall_o,
    output logic [D_WORD-1:0] m_valM_o,
    output logic [NIBBLE-1:0] m_stat_o,
    mem_stage_if.master       dmem,
    output logic [NIBBLE-1:0] W_stat_o,
    output logic [NIBBLE-1:0] W_icode_o,
    output logic [D_WORD-1:0] W_valE_o,
    output logic [D_WORD-1:0] W_valM_o,
    output logic [NIBBLE-1:0] W_dstE_o,
    output logic [NIBBLE-1:0] W_dstM_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    // Largest start address whose 8-byte word still fits in memory.
    localparam logic [D_WORD-1:0] ADDR_MAX = D_WORD'(MEM_BYTES - 8);

    mem_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              halted;
    logic              req_q, we_q;
    logic [D_WORD-1:0] addr_q, wdata_q;

    logic              is_read, is_write, mem_op, in_range, timed_out;
    logic [D_WORD-1:0] acc_addr;
    logic              stall, w_bubble, start, finish;
    logic [NIBBLE-1:0] w_stat;
    logic [D_WORD-1:0] w_valm;

    // Decode the instruction sitting in M.
    always_comb begin
        is_read   = icode_reads(M_icode_i);
        is_write  = icode_writes(M_icode_i);
        acc_addr  = icode_addr_from_vala(M_icode_i) ? M_valA_i : M_valE_i;
        mem_op    = (is_read || is_write) && (M_stat_i == SAOK) && !halted;
        in_range  = (acc_addr <= ADDR_MAX);
        timed_out = (cnt == CNT_LAST);
    end

    // Next-state and per-cycle control; ack beats timeout when both happen together.
    always_comb begin
        state_n  = state;
        stall    = 1'b0;
        w_bubble = 1'b0;
        w_stat   = M_stat_i;
        w_valm   = '0;
        start    = 1'b0;
        finish   = 1'b0;
        if (rst_n_i) begin
            if (state == ST_IDLE) begin
                if (mem_op) begin
                    if (!in_range) begin
                        w_stat = SADR;
                    end else begin
                        start    = 1'b1;
                        stall    = 1'b1;
                        w_bubble = 1'b1;
                        state_n  = ST_BUSY;
                    end
                end
            end else begin
                if (dmem.ack || timed_out) begin
                    finish  = 1'b1;
                    state_n = ST_IDLE;
                    w_stat  = (!dmem.ack || dmem.err) ? SADR : SAOK;
                    if (dmem.ack && !we_q) begin
                        w_valm = dmem.rdata;
                    end
                end else begin
                    stall    = 1'b1;
                    w_bubble = 1'b1;
                end
            end
        end
    end

    // Forwarding taps mirror exactly what W captures at the coming edge.
    always_comb begin
        m_stall_o = stall;
        m_stat_o  = w_bubble ? SBUB : w_stat;
        m_valM_o  = w_valm;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request registers stay frozen for the whole access; counter measures BUSY cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            halted  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= is_write;
                addr_q  <= acc_addr;
                wdata_q <= M_valA_i;
                cnt     <= '0;
            end else if (finish) begin
                req_q <= 1'b0;
                cnt   <= '0;
            end else if (state == ST_BUSY) begin
                cnt <= cnt + 1'b1;
            end
            if (!w_bubble && stat_halts(m_stat_o)) begin
                halted <= 1'b1;
            end
        end
    end

    always_comb begin
        dmem.req   = req_q;
        dmem.we    = we_q;
        dmem.addr  = addr_q;
        dmem.wdata = wdata_q;
    end

    mem_stage_wb_reg u_wb_reg (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .bubble     (w_bubble),
        .next_stat  (m_stat_o),
        .next_icode (M_icode_i),
        .next_vale  (M_valE_i),
        .next_valm  (w_valm),
        .next_dste  (M_dstE_i),
        .next_dstm  (M_dstM_i),
        .stat       (W_stat_o),
        .icode      (W_icode_o),
        .vale       (W_valE_o),
        .valm       (W_valM_o),
        .dste       (W_dstE_o),
        .dstm       (W_dstM_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic        m_stall;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_if dmem();

    mem_stage #(.MEM_BYTES(8192), .TIMEOUT(64)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .M_stat_i  (M_stat),
        .M_icode_i (M_icode),
        .M_valE_i  (M_valE),
        .M_valA_i  (M_valA),
        .M_dstE_i  (M_dstE),
        .M_dstM_i  (M_dstM),
        .m_stall_o (m_stall),
        .m_valM_o  (m_valM),
        .m_stat_o  (m_stat),
        .dmem      (dmem),
        .W_stat_o  (W_stat),
        .W_icode_o (W_icode),
        .W_valE_o  (W_valE),
        .W_valM_o  (W_valM),
        .W_dstE_o  (W_dstE),
        .W_dstM_o  (W_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dmem.ack = 1'b0;
        dmem.err = 1'b0;
        dmem.rdata = '0;
        set_m(SBUB, INOP, 64'h0, 64'h0, RNONE, RNONE);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Runs the instruction held in M to completion; memory acks on BUSY cycle ack_at (0 = never).
    task automatic run_op(input int ack_at, input logic [63:0] rd, input logic er,
                          output int stalls, output int reqs, output int bub_bad,
                          output logic cap_we, output logic [63:0] cap_addr,
                          output logic [63:0] cap_wdata, output logic [3:0] fin_stat,
                          output logic [63:0] fin_valm);
        int   busy_n;
        bit   done;
        logic prev_req;
        logic was_stall;
        stalls = 0; reqs = 0; bub_bad = 0; busy_n = 0; done = 0; prev_req = 1'b0;
        cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; fin_stat = '0; fin_valm = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (dmem.req) begin
                busy_n++;
                if (!prev_req) begin
                    reqs++;
                    cap_we = dmem.we;
                    cap_addr = dmem.addr;
                    cap_wdata = dmem.wdata;
                end
            end
            prev_req = dmem.req;
            dmem.ack = dmem.req && (busy_n == ack_at);
            dmem.rdata = rd;
            dmem.err = er;
            #1;
            was_stall = m_stall;
            if (was_stall) begin
                stalls++;
            end else begin
                done = 1;
                fin_stat = m_stat;
                fin_valm = m_valM;
            end
            tick();
            dmem.ack = 1'b0;
            if (was_stall && W_stat != SBUB) bub_bad++;
        end
        check("op_completes", 64'(done), 64'd1);
    endtask

    int          stalls, reqs, bub_bad;
    logic        cap_we;
    logic [63:0] cap_addr, cap_wdata, fin_valm;
    logic [3:0]  fin_stat;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check("rst_w_stat", 64'(W_stat), 64'(SBUB));
        check("rst_w_icode", 64'(W_icode), 64'(INOP));
        check("rst_w_dste", 64'(W_dstE), 64'hF);
        check("rst_w_dstm", 64'(W_dstM), 64'hF);
        check("rst_w_vale", W_valE, 64'h0);
        check("rst_w_valm", W_valM, 64'h0);
        check("rst_req", 64'(dmem.req), 64'd0);
        check("rst_we", 64'(dmem.we), 64'd0);
        check("rst_addr", dmem.addr, 64'h0);
        check("rst_wdata", dmem.wdata, 64'h0);
        #1;
        check("rst_stall", 64'(m_stall), 64'd0);

        // opq: passes straight through in one cycle
        set_m(SAOK, 4'h6, 64'h10, 64'h0, 4'h3, RNONE);
        run_op(1, 64'h0, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("opq_stalls", 64'(stalls), 64'd0);
        check("opq_reqs", 64'(reqs), 64'd0);
        check("opq_w_vale", W_valE, 64'h10);
        check("opq_w_dste", 64'(W_dstE), 64'h3);
        check("opq_w_stat", 64'(W_stat), 64'(SAOK));
        check("opq_w_valm", W_valM, 64'h0);

        // mrmovq 0x100, ack on third BUSY cycle
        set_m(SAOK, IMRMOVQ, 64'h100, 64'h0, RNONE, 4'h2);
        run_op(3, 64'hDEAD, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("mrm_stalls", 64'(stalls), 64'd3);
        check("mrm_reqs", 64'(reqs), 64'd1);
        check("mrm_bubbles", 64'(bub_bad), 64'd0);
        check("mrm_we", 64'(cap_we), 64'd0);
        check("mrm_addr", cap_addr, 64'h100);
        check("mrm_fwd_valm", fin_valm, 64'hDEAD);
        check("mrm_fwd_stat", 64'(fin_stat), 64'(SAOK));
        check("mrm_w_valm", W_valM, 64'hDEAD);
        check("mrm_w_stat", 64'(W_stat), 64'(SAOK));
        check("mrm_w_dstm", 64'(W_dstM), 64'h2);
        check("mrm_req_drop", 64'(dmem.req), 64'd0);

        // pushq: address from valE, data from valA, ack immediately
        set_m(SAOK, IPUSHQ, 64'h1F8, 64'h55, 4'h4, RNONE);
        run_op(1, 64'hFFFF, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("push_stalls", 64'(stalls), 64'd1);
        check("push_reqs", 64'(reqs), 64'd1);
        check("push_we", 64'(cap_we), 64'd1);
        check("push_addr", cap_addr, 64'h1F8);
        check("push_wdata", cap_wdata, 64'h55);
        check("push_w_valm", W_valM, 64'h0);
        check("push_w_vale", W_valE, 64'h1F8);
        check("push_req_drop", 64'(dmem.req), 64'd0);

        // mrmovq at the last in-range address
        set_m(SAOK, IMRMOVQ, 64'd8184, 64'h0, RNONE, 4'h1);
        run_op(1, 64'h1234, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("edge_reqs", 64'(reqs), 64'd1);
        check("edge_w_stat", 64'(W_stat), 64'(SAOK));
        check("edge_w_valm", W_valM, 64'h1234);

        // rmmovq past the end: no request, SADR, then halted
        set_m(SAOK, IRMMOVQ, 64'd8188, 64'h7, RNONE, RNONE);
        run_op(1, 64'h0, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("oob_stalls", 64'(stalls), 64'd0);
        check("oob_reqs", 64'(reqs), 64'd0);
        check("oob_fwd_stat", 64'(fin_stat), 64'(SADR));
        check("oob_w_stat", 64'(W_stat), 64'(SADR));
        check("oob_w_valm", W_valM, 64'h0);

        set_m(SAOK, IPUSHQ, 64'h100, 64'h9, 4'h4, RNONE);
        run_op(1, 64'h0, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("halt_stalls", 64'(stalls), 64'd0);
        check("halt_reqs", 64'(reqs), 64'd0);
        check("halt_w_stat", 64'(W_stat), 64'(SAOK));
        check("halt_w_icode", 64'(W_icode), 64'(IPOPQ - 4'h1));

        // popq never acknowledged: timeout after 64 stall cycles
        do_reset();
        set_m(SAOK, IPOPQ, 64'h208, 64'h200, 4'h4, 4'h3);
        run_op(0, 64'h0, 1'b0, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("to_stalls", 64'(stalls), 64'd64);
        check("to_reqs", 64'(reqs), 64'd1);
        check("to_bubbles", 64'(bub_bad), 64'd0);
        check("to_addr", cap_addr, 64'h200);
        check("to_w_stat", 64'(W_stat), 64'(SADR));
        check("to_req_drop", 64'(dmem.req), 64'd0);

        // read acknowledged with error
        do_reset();
        set_m(SAOK, IMRMOVQ, 64'h80, 64'h0, RNONE, 4'h6);
        run_op(2, 64'h77, 1'b1, stalls, reqs, bub_bad, cap_we, cap_addr, cap_wdata, fin_stat, fin_valm);
        check("err_stalls", 64'(stalls), 64'd2);
        check("err_w_stat", 64'(W_stat), 64'(SADR));
        check("err_w_dstm", 64'(W_dstM), 64'h6);

        // reset during the second BUSY cycle, late ack afterwards
        do_reset();
        set_m(SAOK, IMRMOVQ, 64'h40, 64'h0, RNONE, 4'h5);
        tick();
        check("rb_req_hi", 64'(dmem.req), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rb_stall_in_rst", 64'(m_stall), 64'd0);
        tick();
        rst_n = 1'b1;
        check("rb_req_lo", 64'(dmem.req), 64'd0);
        check("rb_w_stat", 64'(W_stat), 64'(SBUB));
        check("rb_w_icode", 64'(W_icode), 64'(INOP));
        set_m(SBUB, INOP, 64'h0, 64'h0, RNONE, RNONE);
        dmem.ack = 1'b1;
        dmem.rdata = 64'hBAD;
        #1;
        check("rb_late_stall", 64'(m_stall), 64'd0);
        check("rb_late_fwd", m_valM, 64'h0);
        tick();
        dmem.ack = 1'b0;
        check("rb_late_w_valm", W_valM, 64'h0);
        check("rb_late_w_stat", 64'(W_stat), 64'(SBUB));
        check("rb_late_req", 64'(dmem.req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
